prbs31_checker: RTL and testbench

Receive-side PRBS31 checker that consumes the serial bit stream produced by the PRBS31 generator (polynomial x^31 + x^28 + 1) and measures link integrity. It hunts for sequence alignment, declares lock, then counts bit errors against a free-running local reference. It sits directly downstream of the generator, either internally in loopback or externally on the received pin, and drives lock, error-pulse and counter outputs to the top-level I/O mux.

---
 rtl/prbs31_checker.sv | 146 ++++++++++++++
 tb/tb_prbs31_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker: hunt, verify, lock, count errors.
// Define PRBS31_CHK_RELOCK_EN to drop lock on ERR_THRESH errors per 64-bit window.
module prbs31_checker #(
    parameter int CNT_W      = 16,
    parameter int ERR_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [30:0]      sr_q, sr_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             p;
    logic             bad;

`ifdef PRBS31_CHK_RELOCK_EN
    localparam int WE_W = $clog2(ERR_THRESH + 1);
    localparam logic [WE_W-1:0] THRESH_M1 = WE_W'(ERR_THRESH - 1);

    logic [5:0]      win_cnt_q, win_cnt_d;
    logic [WE_W-1:0] win_err_q, win_err_d;
`endif

    assign p   = sr_q[30] ^ sr_q[27];
    assign bad = (din != p);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
`ifdef PRBS31_CHK_RELOCK_EN
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
`endif
        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    sr_d = {sr_q[29:0], din};
                    if (cnt_q == 6'd30) begin
                        state_d = VERIFY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                VERIFY: begin
                    sr_d = {sr_q[29:0], din};
                    // an all-zero register predicts zeros forever: treat as no signal
                    if (bad || sr_q == '0) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else if (cnt_q == 6'd30) begin
                        state_d = LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                LOCK: begin
                    // self-running reference so a line error is not propagated
                    sr_d  = {sr_q[29:0], p};
                    err_d = bad;
                    if (bad && err_count_q != CNT_MAX)
                        err_count_d = err_count_q + CNT_W'(1);
                    if (bit_count_q != CNT_MAX)
                        bit_count_d = bit_count_q + CNT_W'(1);
`ifdef PRBS31_CHK_RELOCK_EN
                    win_cnt_d = win_cnt_q + 6'd1;
                    if (bad && win_err_q == THRESH_M1) begin
                        state_d   = HUNT;
                        cnt_d     = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == 6'd63) begin
                        win_err_d = '0;
                    end else if (bad) begin
                        win_err_d = win_err_q + WE_W'(1);
                    end
`endif
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
        if (clr) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
`ifdef PRBS31_CHK_RELOCK_EN
            win_cnt_q   <= '0;
            win_err_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
`ifdef PRBS31_CHK_RELOCK_EN
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
`endif
        end
    end

    assign locked    = (state_q == LOCK);
    assign err       = err_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: CNT_W=16 and CNT_W=4 instances share stimulus.
// Expectations follow PRBS31_CHK_RELOCK_EN when it is defined for the build.
module tb_prbs31_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        lk16, er16, lk4, er4;
    logic [15:0] ec16, bc16;
    logic [3:0]  ec4, bc4;

    always #5 clk = ~clk;

    prbs31_checker #(.CNT_W(16), .ERR_THRESH(8)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
        .locked(lk16), .err(er16), .err_count(ec16), .bit_count(bc16)
    );

    prbs31_checker #(.CNT_W(4), .ERR_THRESH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
        .locked(lk4), .err(er4), .err_count(ec4), .bit_count(bc4)
    );

    typedef struct packed {
        logic [7:0]  ph;
        logic        lk;
        logic        er;
        logic [15:0] ec16;
        logic [15:0] bc16;
        logic [3:0]  ec4;
        logic [3:0]  bc4;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    int          ph = 0;
    logic [30:0] g = '1;
    int          vcount = 0;
    int          perr = 0;
    int          m_ec16 = 0, m_bc16 = 0, m_ec4 = 0, m_bc4 = 0;
    logic        relock_phase = 1'b0;

    function automatic int sat(input int x, input int mx);
        return (x < mx) ? x + 1 : x;
    endfunction

    task automatic chk(input string nm, input int p, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s ph%0d t=%0t actual=%0d required=%0d", nm, p, $time, act, req);
        end
    endtask

    // Monitor: one record per driven cycle, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("locked16", int'(e.ph), int'(lk16), int'(e.lk));
                chk("err16", int'(e.ph), int'(er16), int'(e.er));
                chk("err_count16", int'(e.ph), int'(ec16), int'(e.ec16));
                chk("bit_count16", int'(e.ph), int'(bc16), int'(e.bc16));
                chk("locked4", int'(e.ph), int'(lk4), int'(e.lk));
                chk("err4", int'(e.ph), int'(er4), int'(e.er));
                chk("err_count4", int'(e.ph), int'(ec4), int'(e.ec4));
                chk("bit_count4", int'(e.ph), int'(bc4), int'(e.bc4));
            end
        end
    end

    // Drive one cycle and push what the outputs must be after its edge.
    task automatic step(input logic r, input logic v, input logic flip,
                        input logic c, input logic zero);
        exp_t e;
        logic d;
        logic was;
        @(negedge clk);
        rst_n     = r;
        din_valid = v;
        clr       = c;
        e         = '0;
        e.ph      = 8'(ph);
        if (!r) begin
            din    = 1'b1;
            vcount = 0;
            perr   = 0;
            g      = '1;
            m_ec16 = 0; m_bc16 = 0; m_ec4 = 0; m_bc4 = 0;
        end else begin
            if (v) begin
                d   = zero ? 1'b0 : ((g[30] ^ g[27]) ^ flip);
                g   = {g[29:0], g[30] ^ g[27]};
                was = (vcount >= 62) && !zero;
                if (was) begin
                    m_bc16 = sat(m_bc16, 65535);
                    m_bc4  = sat(m_bc4, 15);
                    if (flip) begin
                        e.er   = 1'b1;
                        m_ec16 = sat(m_ec16, 65535);
                        m_ec4  = sat(m_ec4, 15);
                        perr++;
`ifdef PRBS31_CHK_RELOCK_EN
                        if (relock_phase && perr == 8) vcount = -1;
`endif
                    end
                end
                vcount++;
                din = d;
            end else begin
                din = 1'($urandom_range(0, 1));
            end
            if (c) begin
                m_ec16 = 0; m_bc16 = 0; m_ec4 = 0; m_bc4 = 0;
            end
        end
        e.lk   = (vcount >= 62) && !zero;
        e.ec16 = 16'(m_ec16);
        e.bc16 = 16'(m_bc16);
        e.ec4  = 4'(m_ec4);
        e.bc4  = 4'(m_bc4);
        sbq.push_back(e);
    endtask

    // Idle cycle whose expectation is given as hand-computed constants.
    task automatic hold_check(input logic lk, input int e16, input int b16,
                              input int e4, input int b4);
        exp_t e;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e      = sbq.pop_back();
        e.lk   = lk;
        e.er   = 1'b0;
        e.ec16 = 16'(e16);
        e.bc16 = 16'(b16);
        e.ec4  = 4'(e4);
        e.bc4  = 4'(b4);
        sbq.push_back(e);
    endtask

    initial begin
        ph = 0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold_check(1'b0, 0, 0, 0, 0);

        ph = 1;
        repeat (61) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_check(1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_check(1'b1, 0, 0, 0, 0);
        repeat (938) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_check(1'b1, 0, 938, 0, 15);

        ph = 2;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 300; i++)
            step(1'b1, 1'b1, i == 200, 1'b0, 1'b0);
        hold_check(1'b1, 1, 238, 1, 15);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        hold_check(1'b1, 0, 0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        hold_check(1'b1, 0, 0, 0, 0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_check(1'b1, 0, 5, 0, 5);

        ph = 3;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (200) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        hold_check(1'b0, 0, 0, 0, 0);

        ph = 4;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++)
            step(1'b1, (i % 2) == 0, 1'b0, 1'b0, 1'b0);
        hold_check(1'b1, 0, 38, 0, 15);

        ph = 5;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        relock_phase = 1'b1;
        for (int i = 1; i <= 250; i++)
            step(1'b1, 1'b1, (i >= 70) && (i <= 77), 1'b0, 1'b0);
        relock_phase = 1'b0;
`ifdef PRBS31_CHK_RELOCK_EN
        hold_check(1'b1, 8, 126, 8, 15);
`else
        hold_check(1'b1, 8, 188, 8, 15);
`endif

        ph = 6;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 300; i++)
            step(1'b1, 1'b1, (i >= 70) && (i <= 260) && (i % 10 == 0), 1'b0, 1'b0);
        hold_check(1'b1, 20, 238, 15, 15);

        ph = 7;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (61) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_check(1'b0, 0, 0, 0, 0);
        repeat (39) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold_check(1'b1, 0, 38, 0, 15);

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
